// File: rtl/difftest_trap_event_gen.sv
// rtl/difftest_trap_event_gen.sv - difftest trap-event producer: cycle/instr counters, WFI, trap latch, watchdog
module difftest_trap_event_gen #(
  parameter int          COMMIT_WIDTH = 6,
  parameter int          CNT_W        = 3,
  parameter int          TIMEOUT      = 5000,
  parameter logic [31:0] TIMEOUT_CODE = 32'h3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_report_en,
  input  logic [CNT_W-1:0] i_commit_cnt,
  input  logic [63:0]      i_commit_pc,
  input  logic             i_trap_valid,
  input  logic [31:0]      i_trap_code,
  input  logic [63:0]      i_trap_pc,
  input  logic             i_wfi,
  input  logic [7:0]       i_coreid,
  output logic             o_enable,
  output logic             o_hasTrap,
  output logic [63:0]      o_cycleCnt,
  output logic [63:0]      o_instrCnt,
  output logic             o_hasWFI,
  output logic [31:0]      o_code,
  output logic [63:0]      o_pc,
  output logic [7:0]       o_coreid
);

  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] TRAPPED = 1'b1;

  logic [0:0]  state;
  logic [63:0] last_pc;
  logic [31:0] idle_cnt;
  logic [63:0] commit_ext;
  logic [63:0] commit_add;
  logic        has_commit;
  logic        idle_now;
  logic        wdog_expire;

  // Out-of-range commit counts clamp to the retire width instead of wrapping.
  always_comb begin
    commit_ext  = 64'(i_commit_cnt);
    commit_add  = (commit_ext > 64'(COMMIT_WIDTH)) ? 64'(COMMIT_WIDTH) : commit_ext;
    has_commit  = (i_commit_cnt != '0);
    idle_now    = !has_commit && !i_wfi;
    wdog_expire = (TIMEOUT != 0) && idle_now && !i_trap_valid &&
                  (idle_cnt == 32'(TIMEOUT - 1));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      last_pc    <= '0;
      idle_cnt   <= '0;
      o_enable   <= 1'b0;
      o_hasTrap  <= 1'b0;
      o_cycleCnt <= '0;
      o_instrCnt <= '0;
      o_hasWFI   <= 1'b0;
      o_code     <= '0;
      o_pc       <= '0;
      o_coreid   <= '0;
    end else begin
      o_enable <= i_report_en;
      o_hasWFI <= i_wfi;
      o_coreid <= i_coreid;
      if (state == RUN) begin
        o_cycleCnt <= o_cycleCnt + 64'd1;
        o_instrCnt <= o_instrCnt + commit_add;
        if (has_commit) last_pc <= i_commit_pc;
        if (idle_now) idle_cnt <= idle_cnt + 32'd1;
        else          idle_cnt <= '0;
        // A core trap takes priority over a coincident watchdog expiry.
        if (i_trap_valid) begin
          state     <= TRAPPED;
          o_hasTrap <= 1'b1;
          o_code    <= i_trap_code;
          o_pc      <= i_trap_pc;
        end else if (wdog_expire) begin
          state     <= TRAPPED;
          o_hasTrap <= 1'b1;
          o_code    <= TIMEOUT_CODE;
          o_pc      <= last_pc;
        end
      end
    end
  end

endmodule
